// File: rtl/effects_channel_scheduler.sv
// Round-robin scheduler sharing one fixed-latency effects datapath between two
// audio channels, with per-channel gain ramping and tagged result routing.
module effects_channel_scheduler #(
    parameter int DATA_W    = 16,
    parameter int GAIN_W    = 11,
    parameter int LATENCY   = 2,
    parameter int RAMP_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in0_sample,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in1_sample,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [GAIN_W-1:0] gain0_target,
    input  logic [GAIN_W-1:0] gain1_target,
    output logic [DATA_W-1:0] dp_sample,
    output logic [GAIN_W-1:0] dp_gain,
    output logic              dp_valid,
    input  logic [DATA_W-1:0] dp_result,
    output logic [DATA_W-1:0] out0_sample,
    output logic              out0_valid,
    output logic [DATA_W-1:0] out1_sample,
    output logic              out1_valid,
    output logic              busy
);

    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

    logic               last_grant;
    logic               grant0;
    logic               grant1;
    logic               accept;
    logic               accept_chan;
    logic [GAIN_W-1:0]  gain_cur0;
    logic [GAIN_W-1:0]  gain_cur1;
    logic               dp_chan;
    logic [LATENCY-1:0] tag_valid;
    logic [LATENCY-1:0] tag_chan;

    // Moves the current gain toward the target by at most STEP, landing exactly on it.
    function automatic logic [GAIN_W-1:0] ramp(input logic [GAIN_W-1:0] cur,
                                               input logic [GAIN_W-1:0] target);
        logic [GAIN_W-1:0] diff;
        if (target > cur) begin
            diff = target - cur;
            ramp = (diff > STEP) ? cur + STEP : target;
        end else begin
            diff = cur - target;
            ramp = (diff > STEP) ? cur - STEP : target;
        end
    endfunction

    always_comb begin
        grant0 = in0_valid & (~in1_valid | last_grant);
        grant1 = in1_valid & (~in0_valid | ~last_grant);
    end

    assign in0_ready   = grant0 & ~reset;
    assign in1_ready   = grant1 & ~reset;
    assign accept      = in0_ready | in1_ready;
    assign accept_chan = in1_ready;
    assign busy        = dp_valid | (|tag_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            gain_cur0  <= '0;
            gain_cur1  <= '0;
            dp_valid   <= 1'b0;
            dp_sample  <= '0;
            dp_gain    <= '0;
            dp_chan    <= 1'b0;
        end else begin
            dp_valid <= accept;
            if (accept) begin
                last_grant <= accept_chan;
                dp_chan    <= accept_chan;
                if (accept_chan) begin
                    dp_sample <= in1_sample;
                    dp_gain   <= gain_cur1;
                    gain_cur1 <= ramp(gain_cur1, gain1_target);
                end else begin
                    dp_sample <= in0_sample;
                    dp_gain   <= gain_cur0;
                    gain_cur0 <= ramp(gain_cur0, gain0_target);
                end
            end
        end
    end

    // Tags trail dp_valid so the last stage lines up with the cycle dp_result is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid   <= '0;
            tag_chan    <= '0;
            out0_sample <= '0;
            out1_sample <= '0;
            out0_valid  <= 1'b0;
            out1_valid  <= 1'b0;
        end else begin
            tag_valid[0] <= dp_valid;
            tag_chan[0]  <= dp_chan;
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_chan[i]  <= tag_chan[i-1];
            end
            out0_valid <= tag_valid[LATENCY-1] & ~tag_chan[LATENCY-1];
            out1_valid <= tag_valid[LATENCY-1] &  tag_chan[LATENCY-1];
            if (tag_valid[LATENCY-1]) begin
                if (tag_chan[LATENCY-1]) begin
                    out1_sample <= dp_result;
                end else begin
                    out0_sample <= dp_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_effects_channel_scheduler.sv
// Directed testbench for effects_channel_scheduler with a doubling 2-cycle datapath model.
module tb_effects_channel_scheduler;

    logic        clk;
    logic        reset;
    logic [15:0] in0_sample;
    logic        in0_valid;
    logic        in0_ready;
    logic [15:0] in1_sample;
    logic        in1_valid;
    logic        in1_ready;
    logic [10:0] gain0_target;
    logic [10:0] gain1_target;
    logic [15:0] dp_sample;
    logic [10:0] dp_gain;
    logic        dp_valid;
    logic [15:0] dp_result;
    logic [15:0] out0_sample;
    logic        out0_valid;
    logic [15:0] out1_sample;
    logic        out1_valid;
    logic        busy;

    int checks;
    int failures;

    logic [15:0] pipe1;
    logic [15:0] pipe2;

    effects_channel_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .in0_sample   (in0_sample),
        .in0_valid    (in0_valid),
        .in0_ready    (in0_ready),
        .in1_sample   (in1_sample),
        .in1_valid    (in1_valid),
        .in1_ready    (in1_ready),
        .gain0_target (gain0_target),
        .gain1_target (gain1_target),
        .dp_sample    (dp_sample),
        .dp_gain      (dp_gain),
        .dp_valid     (dp_valid),
        .dp_result    (dp_result),
        .out0_sample  (out0_sample),
        .out0_valid   (out0_valid),
        .out1_sample  (out1_sample),
        .out1_valid   (out1_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: result is twice the issued sample, two cycles after dp_valid.
    always @(posedge clk) begin
        pipe1 <= dp_sample << 1;
        pipe2 <= pipe1;
    end
    assign dp_result = pipe2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({in0_ready, in1_ready} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b expected 00", {in0_ready, in1_ready});
        end
        checks++;
        if ({dp_valid, dp_sample, dp_gain} !== 28'h0) begin
            failures++;
            $display("[TB] FAIL reset_dp: got %b/%h/%0d expected 0/0000/0", dp_valid, dp_sample, dp_gain);
        end
        checks++;
        if ({out0_valid, out1_valid, out0_sample, out1_sample, busy} !== 35'h0) begin
            failures++;
            $display("[TB] FAIL reset_out: got v=%b%b s0=%h s1=%h busy=%b expected all 0",
                     out0_valid, out1_valid, out0_sample, out1_sample, busy);
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_issue;
        in0_sample = 16'h1234;
        in0_valid = 1'b1;
        #1;
        checks++;
        if ({in0_ready, in1_ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL single_ready: got %b expected 10", {in0_ready, in1_ready});
        end
        tick();
        in0_valid = 1'b0;
        checks++;
        if ({dp_valid, dp_sample, dp_gain, busy} !== {1'b1, 16'h1234, 11'd0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL single_issue: got v=%b s=%h g=%0d busy=%b expected 1/1234/0/1",
                     dp_valid, dp_sample, dp_gain, busy);
        end
        for (int e = 2; e <= 5; e++) begin
            tick();
            checks++;
            if ({out0_valid, out1_valid} !== {(e == 4), 1'b0}) begin
                failures++;
                $display("[TB] FAIL single_strobe_T%0d: got %b%b expected %b0",
                         e, out0_valid, out1_valid, (e == 4));
            end
        end
        checks++;
        if ({out0_sample, busy, dp_valid} !== {16'h2468, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL single_result: got s=%h busy=%b dpv=%b expected 2468/0/0",
                     out0_sample, busy, dp_valid);
        end
    endtask

    task automatic test_back_to_back;
        int a;
        do_reset();
        in0_sample = 16'h0101;
        in1_sample = 16'h0202;
        for (int e = 0; e < 10; e++) begin
            in0_valid = (e < 6);
            in1_valid = (e < 6);
            if (e < 6) begin
                #1;
                checks++;
                if ({in0_ready, in1_ready} !== ((e % 2 == 0) ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("[TB] FAIL b2b_grant_%0d: got %b expected %b",
                             e, {in0_ready, in1_ready}, ((e % 2 == 0) ? 2'b10 : 2'b01));
                end
            end
            tick();
            if (e < 6) begin
                checks++;
                if ({dp_valid, dp_sample} !== {1'b1, ((e % 2 == 0) ? 16'h0101 : 16'h0202)}) begin
                    failures++;
                    $display("[TB] FAIL b2b_issue_%0d: got %b/%h", e, dp_valid, dp_sample);
                end
            end
            a = e - 3;
            checks++;
            if ({out0_valid, out1_valid} !==
                {(a >= 0 && a < 6 && a % 2 == 0), (a >= 0 && a < 6 && a % 2 == 1)}) begin
                failures++;
                $display("[TB] FAIL b2b_strobe_%0d: got %b%b", e, out0_valid, out1_valid);
            end
            if (a >= 0 && a < 6) begin
                checks++;
                if ((a % 2 == 0) ? (out0_sample !== 16'h0202) : (out1_sample !== 16'h0404)) begin
                    failures++;
                    $display("[TB] FAIL b2b_data_%0d: got s0=%h s1=%h expected 0202/0404",
                             e, out0_sample, out1_sample);
                end
            end
        end
    endtask

    task automatic test_gain_ramp;
        int up[5];
        int down[4];
        up = '{0, 4, 8, 10, 10};
        down = '{10, 6, 2, 1};
        do_reset();
        gain0_target = 11'd10;
        in0_sample = 16'h0055;
        in0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({dp_valid, dp_gain} !== {1'b1, 11'(up[i])}) begin
                failures++;
                $display("[TB] FAIL ramp_up_%0d: got v=%b g=%0d expected 1/%0d", i, dp_valid, dp_gain, up[i]);
            end
        end
        gain0_target = 11'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({dp_valid, dp_gain} !== {1'b1, 11'(down[i])}) begin
                failures++;
                $display("[TB] FAIL ramp_down_%0d: got v=%b g=%0d expected 1/%0d", i, dp_valid, dp_gain, down[i]);
            end
        end
        in0_valid = 1'b0;
        gain0_target = 11'd0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_idle_channel_gain;
        do_reset();
        gain0_target = 11'd0;
        gain1_target = 11'd100;
        in0_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        in0_valid = 1'b0;
        in1_sample = 16'h0777;
        in1_valid = 1'b1;
        tick();
        checks++;
        if ({dp_valid, dp_sample, dp_gain} !== {1'b1, 16'h0777, 11'd0}) begin
            failures++;
            $display("[TB] FAIL idle_ch1_first: got %b/%h/%0d expected 1/0777/0", dp_valid, dp_sample, dp_gain);
        end
        tick();
        checks++;
        if (dp_gain !== 11'd4) begin
            failures++;
            $display("[TB] FAIL idle_ch1_second: got %0d expected 4", dp_gain);
        end
        in1_valid = 1'b0;
        gain1_target = 11'd0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_reset_midflight;
        do_reset();
        in0_sample = 16'h0abc;
        in0_valid = 1'b1;
        tick();
        tick();
        in0_valid = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if ({dp_valid, dp_sample, dp_gain, out0_valid, out1_valid, out0_sample, out1_sample, busy} !== 63'h0) begin
            failures++;
            $display("[TB] FAIL midreset_clear: got dp=%b/%h/%0d out=%b%b/%h/%h busy=%b expected all 0",
                     dp_valid, dp_sample, dp_gain, out0_valid, out1_valid, out0_sample, out1_sample, busy);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({out0_valid, out1_valid, busy} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL midreset_quiet_%0d: got v=%b%b busy=%b expected 000",
                         i, out0_valid, out1_valid, busy);
            end
        end
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        #1;
        checks++;
        if ({in0_ready, in1_ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL midreset_grant: got %b expected 10", {in0_ready, in1_ready});
        end
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_idle;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({in0_ready, in1_ready, dp_valid, busy} !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL idle_%0d: got rdy=%b%b dpv=%b busy=%b expected 0000",
                         i, in0_ready, in1_ready, dp_valid, busy);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        in0_sample = '0;
        in1_sample = '0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        gain0_target = '0;
        gain1_target = '0;
        test_reset();
        test_single_issue();
        test_back_to_back();
        test_gain_ramp();
        test_idle_channel_gain();
        test_reset_midflight();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
